// File: rtl/score4_pkg.sv
// Shared types and constants for the score4 move sequencer.
//   NCOLS       : board width in columns
//   seq_state_t : sequencer FSM states
//   seq_err_t   : error codes reported with err
package score4_pkg;

  localparam int unsigned NCOLS = 7;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StStep,
    StGap,
    StDrop,
    StWaitAck,
    StFinish
  } seq_state_t;

  typedef enum logic [1:0] {
    ErrBadCol    = 2'd0,
    ErrBadCursor = 2'd1,
    ErrRejected  = 2'd2,
    ErrTimeout   = 2'd3
  } seq_err_t;

endpackage

// File: rtl/score4_move_sequencer_if.sv
// Bundle of the move request handshake, game-side cursor/strobe signals and status outputs.
//   master : move requester / game model (drives request and game feedback)
//   slave  : the sequencer (drives ready, strobes and status)
interface score4_move_sequencer_if;
  logic       move_valid;
  logic [2:0] move_col;
  logic       move_ready;
  logic [6:0] play;
  logic       player;
  logic       invalid_move;
  logic       left;
  logic       right;
  logic       put;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output move_valid, move_col, play, player, invalid_move,
    input  move_ready, left, right, put, busy, done, err, err_code
  );

  modport slave (
    input  move_valid, move_col, play, player, invalid_move,
    output move_ready, left, right, put, busy, done, err, err_code
  );
endinterface

// File: rtl/score4_onehot_idx.sv
// Combinational one-hot cursor decoder.
//   onehot_i    : one-hot column vector, bit 0 = leftmost
//   idx_o       : index of the highest set bit (0 when none set)
//   onehot_ok_o : high when exactly one bit is set
module score4_onehot_idx
  import score4_pkg::*;
(
  input  logic [NCOLS-1:0] onehot_i,
  output logic [2:0]       idx_o,
  output logic             onehot_ok_o
);

  localparam logic [NCOLS-1:0] One = NCOLS'(1);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NCOLS; i++) begin
      if (onehot_i[i]) idx_o = 3'(i);
    end
  end

  // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
  assign onehot_ok_o = (onehot_i != '0) && ((onehot_i & (onehot_i - One)) == '0);

endmodule

// File: rtl/score4_move_sequencer.sv
// Turns an automated column choice into left/right/put strobes, then waits for the game to
// acknowledge (player toggle) or reject (invalid_move) the drop.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request handshake, cursor/player feedback, strobes and done/err status
module score4_move_sequencer
  import score4_pkg::*;
#(
  parameter int unsigned PULSE_GAP   = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  score4_move_sequencer_if.slave bus
);

  seq_state_t state_q, state_d;
  seq_err_t   err_code_q, err_code_d;
  logic [2:0] col_q, col_d;
  logic [2:0] step_q, step_d;
  logic [7:0] cnt_q, cnt_d;       // shared by the GAP wait and the ack timeout
  logic       player_q, player_d;
  logic       move_ready_q, move_ready_d;
  logic       left_q, left_d, right_q, right_d, put_q, put_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [2:0] cur_idx;
  logic       cur_ok;

  score4_onehot_idx u_onehot_idx (
    .onehot_i    (bus.play),
    .idx_o       (cur_idx),
    .onehot_ok_o (cur_ok)
  );

  // Outputs are registered, so strobes and status are decided on the transition into a state.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    col_d      = col_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    player_d   = player_q;
    left_d     = 1'b0;
    right_d    = 1'b0;
    put_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.move_valid && move_ready_q) begin
          col_d  = bus.move_col;
          step_d = '0;
          if (bus.move_col > 3'(NCOLS - 1)) begin
            state_d    = StFinish;
            err_d      = 1'b1;
            err_code_d = ErrBadCol;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (!cur_ok) begin
          state_d    = StFinish;
          err_d      = 1'b1;
          err_code_d = ErrBadCursor;
        end else if (cur_idx == col_q) begin
          state_d = StDrop;
          put_d   = 1'b1;
        end else if (step_q == 3'(NCOLS - 1)) begin
          // Six steps already issued without reaching target: cursor is not following.
          state_d    = StFinish;
          err_d      = 1'b1;
          err_code_d = ErrBadCursor;
        end else begin
          state_d = StStep;
          left_d  = (cur_idx > col_q);
          right_d = (cur_idx < col_q);
          step_d  = step_q + 3'd1;
        end
      end
      StStep: begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == 8'(PULSE_GAP - 1)) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDrop: begin
        // Game updates player on the edge that ends this cycle, so this still samples the old one.
        player_d = bus.player;
        cnt_d    = '0;
        state_d  = StWaitAck;
      end
      StWaitAck: begin
        if (bus.invalid_move) begin
          state_d    = StFinish;
          err_d      = 1'b1;
          err_code_d = ErrRejected;
        end else if (bus.player != player_q) begin
          state_d = StFinish;
          done_d  = 1'b1;
        end else if (cnt_q == 8'(ACK_TIMEOUT)) begin
          state_d    = StFinish;
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    move_ready_d = (state_d == StIdle);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      err_code_q   <= ErrBadCol;
      col_q        <= '0;
      step_q       <= '0;
      cnt_q        <= '0;
      player_q     <= 1'b0;
      move_ready_q <= 1'b1;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      put_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      col_q        <= col_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      player_q     <= player_d;
      move_ready_q <= move_ready_d;
      left_q       <= left_d;
      right_q      <= right_d;
      put_q        <= put_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.move_ready = move_ready_q;
  assign bus.left       = left_q;
  assign bus.right      = right_q;
  assign bus.put        = put_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule
